alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one signed ALU (arithmetic, logic, compare and shift units, each with a registered output and a flag) between two requesters.
- Accepts one operation at a time through valid/ready handshakes and arbitrates round-robin.
- Decodes a 4-bit function code into the unit enables and the unit function select, drives the operands, and captures the result.
- Returns the result to the requester that issued the operation. Sits between the command sources and the ALU top.

Parameters:
- IN_DATA_WIDTH, 16, operand width.
- OUT_DATA_WIDTH, 32, ALU result width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- REQ0_VALID  in  1  requester 0 has an operation.
- REQ0_READY  out  1  requester 0 operation accepted this cycle.
- REQ0_A, REQ0_B  in  IN_DATA_WIDTH  requester 0 operands.
- REQ0_FUN  in  4  requester 0 function code.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_FUN: same as requester 0, for requester 1.
- RSP0_VALID  out  1  response pending for requester 0.
- RSP1_VALID  out  1  response pending for requester 1.
- RSP0_READY, RSP1_READY  in  1  requester takes its response.
- RSP_DATA  out  OUT_DATA_WIDTH  result (shared).
- RSP_ERR  out  1  unit flag missing.
- ALU_A, ALU_B  out  IN_DATA_WIDTH  operands to the ALU.
- Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable  out  1  unit enables.
- ALU_FUN_SEL  out  2  unit function select.
- ALU_OUT  in  OUT_DATA_WIDTH  registered ALU result.
- ALU_FLAG  in  1  OR of the unit flags.
- BUSY  out  1  state is not IDLE.

Behaviour:
- Reset (synchronous, RST=1 at the CLK edge): state=IDLE. All outputs 0 (all READY, all RSP_VALID, RSP_DATA, RSP_ERR, ALU_A, ALU_B, all enables, ALU_FUN_SEL, BUSY). LAST=1, so requester 0 wins first.
- Reset mid-operation: the in-flight op is dropped and no response is produced.
- Function code decode, FUN[3:2] selects the unit:
  - 00 = arith, 01 = logic, 10 = cmp, 11 = shift.
  - FUN[1:0] goes to ALU_FUN_SEL.
- FSM, 4 states:
  - IDLE:
    - If exactly one REQx_VALID is high, grant it.
    - If both are high, grant the one that is not LAST.
    - REQx_READY is combinational, high in IDLE for the granted requester only; this is the accept cycle.
    - On accept, latch A, B and FUN into internal registers, set OWNER=x, go to ISSUE.
    - No valid requests: stay in IDLE.
  - ISSUE (1 cycle):
    - ALU_A/ALU_B/ALU_FUN_SEL driven from the latched values.
    - Exactly one unit enable high, per FUN[3:2]. Go to WAIT.
  - WAIT (1 cycle):
    - All enables 0. ALU_OUT and ALU_FLAG now reflect the ISSUE operation.
    - ALU_FLAG=1: RSP_DATA<=ALU_OUT, RSP_ERR<=0.
    - ALU_FLAG=0: RSP_DATA<=0, RSP_ERR<=1.
    - Go to RESP.
  - RESP:
    - RSP<OWNER>_VALID=1. RSP_DATA and RSP_ERR held stable.
    - When RSP<OWNER>_READY=1: LAST<=OWNER, go to IDLE.
    - RSP_READY from the non-owner is ignored.
- ALU_A, ALU_B and ALU_FUN_SEL outside ISSUE: hold their last values; enables are 0.
- Latency: accept edge to RSP_VALID = 3 cycles.
- Minimum spacing between accepts: 4 cycles (IDLE, ISSUE, WAIT, RESP with ready already high).
- One operation outstanding at a time. Requests arriving while BUSY wait with VALID held and are not accepted.
- A requester may drop VALID before READY without penalty.
- Fairness: with both valid continuously, grants alternate 0,1,0,1...
- A single requester may be granted back-to-back.
- Operand and result widths are passed through unchanged; no sign extension or arithmetic is done here.

Test Plan:
- Reset then REQ0 only, A=16'h00F0, B=16'h0FF0, FUN=4'b0100 -> REQ0_READY on the accept cycle; next cycle Logic_Enable=1, ALU_FUN_SEL=00; RSP0_VALID 3 cycles after accept with RSP_DATA=32'h00F0, RSP_ERR=0.
- REQ0 and REQ1 both valid from reset, 4 ops each, RSP_READY tied high -> grant order 0,1,0,1,...; accepts exactly 4 cycles apart.
- REQ1, A=-3 (16'hFFFD), B=5, FUN=4'b0010 (multiply), RSP1_READY low for 5 cycles -> RSP1_VALID held; RSP_DATA=32'hFFFFFFF1 stable throughout; RSP0_VALID stays 0; no new accept until ready.
- ALU model suppresses ALU_FLAG for one op -> RSP_ERR=1, RSP_DATA=0; next op completes normally with RSP_ERR=0.
- RST asserted during WAIT -> next cycle all outputs 0 and BUSY=0; no RSP_VALID ever for the dropped op; next request is granted to requester 0.
- FUN=4'b1111 then FUN=4'b1000 -> Shift_Enable with ALU_FUN_SEL=11, then CMP_Enable with ALU_FUN_SEL=00; only one enable high in any cycle.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - requester, response and ALU-side signals of the ALU request arbiter
// slave: the arbiter itself; master: the requesters and the ALU seen from outside.
interface alu_req_arbiter_if #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 32
);
  logic                      REQ0_VALID;
  logic                      REQ0_READY;
  logic [IN_DATA_WIDTH-1:0]  REQ0_A;
  logic [IN_DATA_WIDTH-1:0]  REQ0_B;
  logic [3:0]                REQ0_FUN;
  logic                      REQ1_VALID;
  logic                      REQ1_READY;
  logic [IN_DATA_WIDTH-1:0]  REQ1_A;
  logic [IN_DATA_WIDTH-1:0]  REQ1_B;
  logic [3:0]                REQ1_FUN;
  logic                      RSP0_VALID;
  logic                      RSP1_VALID;
  logic                      RSP0_READY;
  logic                      RSP1_READY;
  logic [OUT_DATA_WIDTH-1:0] RSP_DATA;
  logic                      RSP_ERR;
  logic [IN_DATA_WIDTH-1:0]  ALU_A;
  logic [IN_DATA_WIDTH-1:0]  ALU_B;
  logic                      Arith_Enable;
  logic                      Logic_Enable;
  logic                      CMP_Enable;
  logic                      Shift_Enable;
  logic [1:0]                ALU_FUN_SEL;
  logic [OUT_DATA_WIDTH-1:0] ALU_OUT;
  logic                      ALU_FLAG;
  logic                      BUSY;

  modport slave (
    input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
    input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
    input  RSP0_READY, RSP1_READY, ALU_OUT, ALU_FLAG,
    output REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP_DATA, RSP_ERR,
    output ALU_A, ALU_B, Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
    output ALU_FUN_SEL, BUSY
  );

  modport master (
    output REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
    output REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
    output RSP0_READY, RSP1_READY, ALU_OUT, ALU_FLAG,
    input  REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP_DATA, RSP_ERR,
    input  ALU_A, ALU_B, Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable,
    input  ALU_FUN_SEL, BUSY
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter sharing one registered ALU between two requesters
// One operation in flight: IDLE accept, ISSUE one unit, WAIT for the registered result, RESP to the owner.
module alu_req_arbiter #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 32
) (
  input logic              CLK,
  input logic              RST,
  alu_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                    state, state_n;
  logic                      last_q;
  logic                      owner_q;
  logic [1:0]                unit_q;
  logic [1:0]                sel_q;
  logic [IN_DATA_WIDTH-1:0]  a_q;
  logic [IN_DATA_WIDTH-1:0]  b_q;
  logic [OUT_DATA_WIDTH-1:0] rsp_data_q;
  logic                      rsp_err_q;

  logic       grant0, grant1;
  logic       rsp0_valid, rsp1_valid;
  logic [3:0] unit_en;
  logic       rsp_taken;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unit_en    = 4'b0000;
    rsp_taken  = 1'b0;
    case (state)
      S_IDLE: begin
        // On contention the requester that was not served last wins
        if (!RST) begin
          grant1 = bus.REQ1_VALID && (!bus.REQ0_VALID || !last_q);
          grant0 = bus.REQ0_VALID && !grant1;
        end
        if (grant0 || grant1) begin
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        unit_en[unit_q] = 1'b1;
        state_n         = S_WAIT;
      end
      S_WAIT: begin
        state_n = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid = owner_q;
        rsp_taken  = owner_q ? bus.RSP1_READY : bus.RSP0_READY;
        if (rsp_taken) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      unit_q     <= 2'b00;
      sel_q      <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        owner_q <= grant1;
        a_q     <= grant1 ? bus.REQ1_A : bus.REQ0_A;
        b_q     <= grant1 ? bus.REQ1_B : bus.REQ0_B;
        unit_q  <= grant1 ? bus.REQ1_FUN[3:2] : bus.REQ0_FUN[3:2];
        sel_q   <= grant1 ? bus.REQ1_FUN[1:0] : bus.REQ0_FUN[1:0];
      end
      // A missing unit flag means no unit produced a result: report an error with zero data
      if (state == S_WAIT) begin
        rsp_data_q <= bus.ALU_FLAG ? bus.ALU_OUT : '0;
        rsp_err_q  <= !bus.ALU_FLAG;
      end
      if (rsp_taken) begin
        last_q <= owner_q;
      end
    end
  end

  assign bus.REQ0_READY   = grant0;
  assign bus.REQ1_READY   = grant1;
  assign bus.RSP0_VALID   = rsp0_valid;
  assign bus.RSP1_VALID   = rsp1_valid;
  assign bus.RSP_DATA     = rsp_data_q;
  assign bus.RSP_ERR      = rsp_err_q;
  assign bus.ALU_A        = a_q;
  assign bus.ALU_B        = b_q;
  assign bus.ALU_FUN_SEL  = sel_q;
  assign bus.Arith_Enable = unit_en[0];
  assign bus.Logic_Enable = unit_en[1];
  assign bus.CMP_Enable   = unit_en[2];
  assign bus.Shift_Enable = unit_en[3];
  assign bus.BUSY         = (state != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - scoreboard bench for alu_req_arbiter with a behavioural registered ALU
module tb_alu_req_arbiter;
  localparam int IW = 16;
  localparam int OW = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_req_arbiter_if #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW)) bus ();
  alu_req_arbiter #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    logic signed [31:0] sa, sb;
    logic [31:0] r;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    case (f)
      4'd0:    r = sa + sb;
      4'd1:    r = sa - sb;
      4'd2:    r = sa * sb;
      4'd3:    r = (sb != 0) ? sa / sb : 32'd0;
      4'd4:    r = {16'h0, a & b};
      4'd5:    r = {16'h0, a | b};
      4'd6:    r = {16'h0, ~(a & b)};
      4'd7:    r = {16'h0, ~(a | b)};
      4'd8:    r = (sa == sb) ? 32'd1 : 32'd0;
      4'd9:    r = (sa > sb) ? 32'd1 : 32'd0;
      4'd10:   r = (sa < sb) ? 32'd1 : 32'd0;
      4'd11:   r = (sa != sb) ? 32'd1 : 32'd0;
      4'd12:   r = {16'h0, a >> 1};
      4'd13:   r = {16'h0, a << 1};
      4'd14:   r = {16'h0, b >> 1};
      default: r = {16'h0, b << 1};
    endcase
    return r;
  endfunction

  // Registered ALU: result and flag appear the cycle after an enable
  logic suppress_op = 1'b0;
  logic [1:0] alu_unit;
  assign alu_unit = bus.Shift_Enable ? 2'd3 : bus.CMP_Enable ? 2'd2 : bus.Logic_Enable ? 2'd1 : 2'd0;

  always @(posedge CLK) begin
    if (RST) begin
      bus.ALU_OUT  <= '0;
      bus.ALU_FLAG <= 1'b0;
    end else if (bus.Arith_Enable || bus.Logic_Enable || bus.CMP_Enable || bus.Shift_Enable) begin
      bus.ALU_OUT  <= alu_ref(bus.ALU_A, bus.ALU_B, {alu_unit, bus.ALU_FUN_SEL});
      bus.ALU_FLAG <= !suppress_op;
    end else begin
      bus.ALU_OUT  <= '0;
      bus.ALU_FLAG <= 1'b0;
    end
  end

  typedef struct {
    logic        owner;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   acc_log[$];
  int   acc_cyc_log[$];
  int   cyc = 0;
  int   acc_cyc = -100;
  int   issue_unit = -1;
  int   issue_sel = -1;
  logic [15:0] acc_a, acc_b;
  logic [3:0]  acc_fun;
  logic        rsp_prev = 1'b0;
  logic [31:0] hold_data;
  logic        hold_err;
  logic [31:0] last_data;
  logic        last_err;

  always @(negedge CLK) begin
    logic [3:0] en;
    logic       taken;
    exp_t       e;
    cyc++;
    if (RST) begin
      rsp_prev = 1'b0;
    end else begin
      en = {bus.Shift_Enable, bus.CMP_Enable, bus.Logic_Enable, bus.Arith_Enable};
      check_eq("ready_while_busy", (bus.REQ0_READY || bus.REQ1_READY) && bus.BUSY, 0);
      check_eq("both_rsp_valid", bus.RSP0_VALID && bus.RSP1_VALID, 0);
      if (bus.REQ0_READY || bus.REQ1_READY) begin
        check_eq("both_ready", bus.REQ0_READY && bus.REQ1_READY, 0);
        e.owner = bus.REQ1_READY;
        acc_a   = e.owner ? bus.REQ1_A : bus.REQ0_A;
        acc_b   = e.owner ? bus.REQ1_B : bus.REQ0_B;
        acc_fun = e.owner ? bus.REQ1_FUN : bus.REQ0_FUN;
        e.err   = suppress_op;
        e.data  = suppress_op ? 32'd0 : alu_ref(acc_a, acc_b, acc_fun);
        sbq.push_back(e);
        acc_log.push_back(int'(e.owner));
        acc_cyc_log.push_back(cyc);
        acc_cyc = cyc;
      end
      if (en != 4'b0000) begin
        check_eq("enable_onehot", $countones(en), 1);
        check_eq("enable_unit", en, 4'b0001 << acc_fun[3:2]);
        check_eq("fun_sel", bus.ALU_FUN_SEL, acc_fun[1:0]);
        check_eq("alu_operands", {bus.ALU_A, bus.ALU_B}, {acc_a, acc_b});
        check_eq("issue_latency", cyc - acc_cyc, 1);
        issue_unit = int'(alu_unit);
        issue_sel  = int'(bus.ALU_FUN_SEL);
      end
      taken = (bus.RSP0_VALID && bus.RSP0_READY) || (bus.RSP1_VALID && bus.RSP1_READY);
      if (bus.RSP0_VALID || bus.RSP1_VALID) begin
        if (!rsp_prev) begin
          check_eq("rsp_latency", cyc - acc_cyc, 3);
        end else begin
          check_eq("rsp_data_stable", bus.RSP_DATA, hold_data);
          check_eq("rsp_err_stable", bus.RSP_ERR, hold_err);
        end
        hold_data = bus.RSP_DATA;
        hold_err  = bus.RSP_ERR;
        if (taken) begin
          if (sbq.size() == 0) begin
            check_eq("rsp_unexpected", sbq.size(), 1);
          end else begin
            e = sbq.pop_front();
            check_eq("rsp_owner", bus.RSP1_VALID, e.owner);
            check_eq("rsp_data", bus.RSP_DATA, e.data);
            check_eq("rsp_err", bus.RSP_ERR, e.err);
          end
          last_data = bus.RSP_DATA;
          last_err  = bus.RSP_ERR;
        end
      end
      rsp_prev = (bus.RSP0_VALID || bus.RSP1_VALID) && !taken;
    end
  end

  task automatic send(input int r, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    if (r == 0) begin
      bus.REQ0_VALID = 1'b1; bus.REQ0_A = a; bus.REQ0_B = b; bus.REQ0_FUN = f;
    end else begin
      bus.REQ1_VALID = 1'b1; bus.REQ1_A = a; bus.REQ1_B = b; bus.REQ1_FUN = f;
    end
    while (!acc && n < 100) begin
      @(negedge CLK);
      n++;
      acc = (r == 0) ? bus.REQ0_READY : bus.REQ1_READY;
    end
    check_eq("accept_timeout", acc, 1);
    @(posedge CLK); #1;
    if (r == 0) bus.REQ0_VALID = 1'b0;
    else        bus.REQ1_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.BUSY && n < 100);
    check_eq("idle_timeout", n < 100, 1);
    @(posedge CLK); #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"}, {bus.REQ0_READY, bus.REQ1_READY, bus.RSP0_VALID, bus.RSP1_VALID,
                             bus.RSP_ERR, bus.Arith_Enable, bus.Logic_Enable, bus.CMP_Enable,
                             bus.Shift_Enable, bus.ALU_FUN_SEL, bus.BUSY}, 0);
    check_eq({tag, "_data"}, {bus.RSP_DATA, bus.ALU_A, bus.ALU_B}, 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    sbq.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    acc_log.delete();
    acc_cyc_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.REQ0_VALID = 1'b0; bus.REQ0_A = '0; bus.REQ0_B = '0; bus.REQ0_FUN = '0;
    bus.REQ1_VALID = 1'b0; bus.REQ1_A = '0; bus.REQ1_B = '0; bus.REQ1_FUN = '0;
    bus.RSP0_READY = 1'b1;
    bus.RSP1_READY = 1'b1;

    do_reset();
    @(negedge CLK);
    check_zero("reset");
    @(posedge CLK); #1;

    // Basic logic AND from requester 0
    send(0, 16'h00F0, 16'h0FF0, 4'b0100);
    wait_idle();
    check_eq("t1_data", last_data, 32'h0000_00F0);
    check_eq("t1_err", last_err, 0);
    check_eq("t1_unit", issue_unit, 1);
    check_eq("t1_sel", issue_sel, 0);

    // Both requesters valid continuously from reset
    do_reset();
    @(posedge CLK); #1;
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 16'(i + 1), 16'(i + 10), 4'b0000);
      end
      begin
        for (int i = 0; i < 4; i++) send(1, 16'(i + 100), 16'(i + 3), 4'b0001);
      end
    join
    wait_idle();
    check_eq("t2_accepts", acc_log.size(), 8);
    for (int i = 0; i < acc_log.size(); i++) begin
      check_eq("t2_grant_order", acc_log[i], i % 2);
      if (i > 0) check_eq("t2_spacing", acc_cyc_log[i] - acc_cyc_log[i-1], 4);
    end

    // Held response: signed multiply, requester 1 not ready for 5 cycles
    bus.RSP1_READY = 1'b0;
    send(1, 16'hFFFD, 16'h0005, 4'b0010);
    fork
      send(0, 16'h0003, 16'h0004, 4'b0000);
      begin
        n = 0;
        do begin
          @(negedge CLK);
          n++;
        end while (!bus.RSP1_VALID && n < 20);
        check_eq("t3_rsp_timeout", n < 20, 1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge CLK);
          check_eq("t3_rsp1_valid", bus.RSP1_VALID, 1);
          check_eq("t3_rsp0_valid", bus.RSP0_VALID, 0);
          check_eq("t3_data", bus.RSP_DATA, 32'hFFFF_FFF1);
          check_eq("t3_no_accept", bus.REQ0_READY, 0);
        end
        @(posedge CLK); #1;
        bus.RSP1_READY = 1'b1;
      end
    join
    wait_idle();

    // Missing unit flag, then a normal operation
    suppress_op = 1'b1;
    send(0, 16'h0007, 16'h0002, 4'b0000);
    wait_idle();
    suppress_op = 1'b0;
    check_eq("t4_err_set", last_err, 1);
    check_eq("t4_data_zero", last_data, 0);
    send(1, 16'h0007, 16'h0002, 4'b0001);
    wait_idle();
    check_eq("t4_err_clear", last_err, 0);
    check_eq("t4_data", last_data, 32'h0000_0005);

    // Reset during WAIT drops the operation
    send(1, 16'h0011, 16'h0022, 4'b0000);
    @(posedge CLK); #1;
    RST = 1'b1;
    sbq.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    acc_log.delete();
    acc_cyc_log.delete();
    @(negedge CLK);
    check_zero("t5_reset");
    repeat (8) @(posedge CLK);
    #1;
    fork
      send(0, 16'h0001, 16'h0001, 4'b0000);
      send(1, 16'h0002, 16'h0002, 4'b0000);
    join
    wait_idle();
    check_eq("t5_accepts", acc_log.size(), 2);
    if (acc_log.size() > 0) check_eq("t5_first_grant", acc_log[0], 0);

    // Shift then compare units
    send(0, 16'h0081, 16'h0003, 4'b1111);
    wait_idle();
    check_eq("t6_shift_unit", issue_unit, 3);
    check_eq("t6_shift_sel", issue_sel, 3);
    send(1, 16'h0005, 16'h0005, 4'b1000);
    wait_idle();
    check_eq("t6_cmp_unit", issue_unit, 2);
    check_eq("t6_cmp_sel", issue_sel, 0);
    check_eq("t6_cmp_data", last_data, 32'h0000_0001);

    check_eq("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
